// File: rtl/ex_mem_reg_pkg.sv
// Shared definitions for the EX->MEM pipeline register.
// Widths, stall-bit indices, write-enable levels and edge-rule decode.
package ex_mem_reg_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_STALL_W   = 6;
    localparam int DEF_EX_STALL  = 3;
    localparam int DEF_MEM_STALL = 4;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // What the register does on a given rising edge
    typedef enum logic [1:0] {
        RULE_FLUSH   = 2'd0,
        RULE_BUBBLE  = 2'd1,
        RULE_ADVANCE = 2'd2,
        RULE_HOLD    = 2'd3
    } ex_mem_rule_e;

    // Flush beats everything; a stalled EX with a running MEM
    // leaves a hole in MEM, otherwise EX either moves on or waits.
    function automatic ex_mem_rule_e ex_mem_rule(
        input logic flush,
        input logic ex_stall,
        input logic mem_stall
    );
        ex_mem_rule_e r;
        r = RULE_HOLD;
        unique case (1'b1)
            flush:                                r = RULE_FLUSH;
            (!flush && ex_stall && !mem_stall):   r = RULE_BUBBLE;
            (!flush && !ex_stall):                r = RULE_ADVANCE;
            default:                              r = RULE_HOLD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall/flush/bubble handling and MADD/MSUB
// feedback. Optional bubble counter when EX_MEM_PERF_EN is defined.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int STALL_W       = DEF_STALL_W,
    parameter int EX_STALL_BIT  = DEF_EX_STALL,
    parameter int MEM_STALL_BIT = DEF_MEM_STALL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
`ifdef EX_MEM_PERF_EN
    output logic [31:0]         perf_bubble_cnt,
`endif
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);

    ex_mem_rule_e rule;
    logic         unused_stall;

    // Only the EX and MEM stall bits matter here
    assign unused_stall = ^stall;

    // Pick the action for the coming edge
    always_comb begin
        rule = ex_mem_rule(flush, stall[EX_STALL_BIT], stall[MEM_STALL_BIT]);
    end

    // GPR and HI/LO writeback bundle towards MEM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd    <= '0;
            mem_wreg  <= WRITE_DISABLE;
            mem_wdata <= '0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_whilo <= WRITE_DISABLE;
        end else begin
            unique case (rule)
                RULE_FLUSH, RULE_BUBBLE: begin
                    mem_wd    <= '0;
                    mem_wreg  <= WRITE_DISABLE;
                    mem_wdata <= '0;
                    mem_hi    <= '0;
                    mem_lo    <= '0;
                    mem_whilo <= WRITE_DISABLE;
                end
                RULE_ADVANCE: begin
                    mem_wd    <= ex_wd;
                    mem_wreg  <= ex_wreg;
                    mem_wdata <= ex_wdata;
                    mem_hi    <= ex_hi;
                    mem_lo    <= ex_lo;
                    mem_whilo <= ex_whilo;
                end
                RULE_HOLD: begin
                    mem_wd    <= mem_wd;
                    mem_wreg  <= mem_wreg;
                    mem_wdata <= mem_wdata;
                    mem_hi    <= mem_hi;
                    mem_lo    <= mem_lo;
                    mem_whilo <= mem_whilo;
                end
                default: begin
                    mem_wd    <= '0;
                    mem_wreg  <= WRITE_DISABLE;
                    mem_wdata <= '0;
                    mem_hi    <= '0;
                    mem_lo    <= '0;
                    mem_whilo <= WRITE_DISABLE;
                end
            endcase
        end
    end

    // MADD/MSUB partial result only survives while EX sits in a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end else begin
            unique case (rule)
                RULE_BUBBLE: begin
                    hilo_o <= hilo_i;
                    cnt_o  <= cnt_i;
                end
                RULE_HOLD: begin
                    hilo_o <= hilo_o;
                    cnt_o  <= cnt_o;
                end
                default: begin
                    hilo_o <= '0;
                    cnt_o  <= '0;
                end
            endcase
        end
    end

`ifdef EX_MEM_PERF_EN
    // Count bubble edges; only reset clears it, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_bubble_cnt <= '0;
        end else if (rule == RULE_BUBBLE) begin
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg.
// Works with or without EX_MEM_PERF_EN defined.
module tb_ex_mem_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
`ifdef EX_MEM_PERF_EN
    logic [31:0] perf_bubble_cnt;
`endif

    int checks = 0;
    int failures = 0;

    ex_mem_reg dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .ex_hi     (ex_hi),
        .ex_lo     (ex_lo),
        .ex_whilo  (ex_whilo),
        .hilo_i    (hilo_i),
        .cnt_i     (cnt_i),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .mem_whilo (mem_whilo),
`ifdef EX_MEM_PERF_EN
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .hilo_o    (hilo_o),
        .cnt_o     (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag, input logic [31:0] exp);
`ifdef EX_MEM_PERF_EN
        chk(tag, {32'd0, perf_bubble_cnt}, {32'd0, exp});
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wd"},    {59'd0, mem_wd}, 64'd0);
        chk({tag, "_wreg"},  {63'd0, mem_wreg}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, "_hi"},    {32'd0, mem_hi}, 64'd0);
        chk({tag, "_lo"},    {32'd0, mem_lo}, 64'd0);
        chk({tag, "_whilo"}, {63'd0, mem_whilo}, 64'd0);
        chk({tag, "_hilo"},  hilo_o, 64'd0);
        chk({tag, "_cnt"},   {62'd0, cnt_o}, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0;
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0;
        ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0;
        hilo_i = '0; cnt_i = '0;

        // Reset state
        tick();
        chk_all_zero("reset");
        chk_perf("reset_perf", 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Advance: GPR writeback; partial product must not leak through
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        hilo_i = 64'h5; cnt_i = 2'd2;
        tick();
        chk("adv_wd",    {59'd0, mem_wd}, 64'd3);
        chk("adv_wreg",  {63'd0, mem_wreg}, 64'd1);
        chk("adv_wdata", {32'd0, mem_wdata}, 64'h1234_5678);
        chk("adv_hilo",  hilo_o, 64'd0);
        chk("adv_cnt",   {62'd0, cnt_o}, 64'd0);

        // HI/LO writeback
        ex_whilo = 1'b1; ex_hi = 32'hFFFF_FFFF; ex_lo = 32'h1;
        tick();
        chk("hilo_whilo", {63'd0, mem_whilo}, 64'd1);
        chk("hilo_hi",    {32'd0, mem_hi}, 64'hFFFF_FFFF);
        chk("hilo_lo",    {32'd0, mem_lo}, 64'h1);

        // Hold for 3 cycles while inputs change
        stall = 6'b011111;
        ex_wd = 5'd9; ex_wdata = 32'hDEAD_BEEF; ex_hi = 32'h0; ex_lo = 32'h7;
        ex_whilo = 1'b0; ex_wreg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_wd",    {59'd0, mem_wd}, 64'd3);
            chk("hold_wreg",  {63'd0, mem_wreg}, 64'd1);
            chk("hold_wdata", {32'd0, mem_wdata}, 64'h1234_5678);
            chk("hold_hi",    {32'd0, mem_hi}, 64'hFFFF_FFFF);
            chk("hold_lo",    {32'd0, mem_lo}, 64'h1);
            chk("hold_whilo", {63'd0, mem_whilo}, 64'd1);
        end

        // Bubble: EX stalled, MEM running
        stall = 6'b001111; hilo_i = 64'hA; cnt_i = 2'd1;
        ex_wreg = 1'b1; ex_whilo = 1'b1;
        tick();
        chk("bub_wreg",  {63'd0, mem_wreg}, 64'd0);
        chk("bub_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("bub_whilo", {63'd0, mem_whilo}, 64'd0);
        chk("bub_wd",    {59'd0, mem_wd}, 64'd0);
        chk("bub_hilo",  hilo_o, 64'hA);
        chk("bub_cnt",   {62'd0, cnt_o}, 64'd1);
        chk_perf("bub_perf", 32'd1);

        // Hold keeps the partial product
        stall = 6'b011111; hilo_i = 64'hF; cnt_i = 2'd3;
        tick();
        chk("hold2_hilo", hilo_o, 64'hA);
        chk("hold2_cnt",  {62'd0, cnt_o}, 64'd1);
        chk_perf("hold2_perf", 32'd1);

        // Non-EX/MEM stall bits ignored: advance
        stall = 6'b100111;
        ex_wd = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hCAFE_0001;
        ex_hi = 32'h8000_0000; ex_lo = 32'h0000_FFFF; ex_whilo = 1'b0;
        tick();
        chk("ign_wd",    {59'd0, mem_wd}, 64'd31);
        chk("ign_wdata", {32'd0, mem_wdata}, 64'hCAFE_0001);
        chk("ign_hi",    {32'd0, mem_hi}, 64'h8000_0000);
        chk("ign_lo",    {32'd0, mem_lo}, 64'h0000_FFFF);
        chk("ign_whilo", {63'd0, mem_whilo}, 64'd0);
        chk("ign_hilo",  hilo_o, 64'd0);

        // Second bubble, then flush over stall
        stall = 6'b001000; hilo_i = 64'h1_0000_000B; cnt_i = 2'd2;
        tick();
        chk("bub2_hilo", hilo_o, 64'h1_0000_000B);
        chk("bub2_cnt",  {62'd0, cnt_o}, 64'd2);
        chk_perf("bub2_perf", 32'd2);

        stall = 6'b001111;
        tick();
        chk_perf("bub3_perf", 32'd3);
        stall = 6'b100111;
        tick();
        chk("adv3_wd", {59'd0, mem_wd}, 64'd31);

        flush = 1'b1; stall = 6'b011111;
        tick();
        chk_all_zero("flush");
        chk_perf("flush_perf", 32'd3);
        flush = 1'b0;

        // Async reset mid-cycle with non-zero state
        stall = 6'b001111; hilo_i = 64'h77; cnt_i = 2'd3;
        tick();
        chk("pre_rst_hilo", hilo_o, 64'h77);
        stall = 6'b000000;
        tick();
        chk("pre_rst_wd", {59'd0, mem_wd}, 64'd31);
        stall = 6'b011111;
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        chk_perf("async_rst_perf", 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("post_rst_hilo",  hilo_o, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
